// File: rtl/morse_symbol_buffer.sv
// Multi-channel Morse symbol capture buffer.
// Each channel stores up to DEPTH symbols, one per rising edge of its
// (already debounced) load button. Symbols are appended in arrival order.
// The block reports a per-channel fill count, a full flag, a one-cycle
// accept pulse and a sticky overflow flag. A registered random-access read
// port serves the downstream compare/scoring logic.
module morse_symbol_buffer #(
    parameter  int WIDTH  = 2,
    parameter  int DEPTH  = 8,
    parameter  int NUM_CH = 2,
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*WIDTH-1:0] d_in,
    input  logic [NUM_CH-1:0]       clr,
    input  logic                    lock,
    input  logic [CHW-1:0]          rd_ch,
    input  logic [IW-1:0]           rd_idx,
    output logic [WIDTH-1:0]        rd_data,
    output logic [NUM_CH*CW-1:0]    count,
    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       accepted,
    output logic [NUM_CH-1:0]       overflow
);

    logic [NUM_CH-1:0] load_q;
    logic [NUM_CH-1:0] rise;
    logic [WIDTH-1:0]  mem [NUM_CH][DEPTH];
    logic [CW-1:0]     cnt [NUM_CH];
    logic [NUM_CH-1:0] acc_q;
    logic [NUM_CH-1:0] ovf_q;
    logic [WIDTH-1:0]  rd_sel;

    // A press is the first cycle the button is seen high.
    assign rise = load & ~load_q;

    // Remember last button level. Reset to ones, so a button held through
    // reset has to be released before it can load a symbol.
    // NOTE: every sequential update uses <=, so all registers sample their
    // inputs from the same clock edge and never see each other's new values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            load_q <= '1;
        end else begin
            load_q <= load;
        end
    end

    // Per-channel storage, fill count, accept pulse and overflow flag.
    // Priority per channel is clear, then lock, then write.
    // NOTE: the symbol store is reset and cleared on purpose: reading an
    // unused slot must return 0 and a fresh round must not see old symbols.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt[c] <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    mem[c][i] <= '0;
                end
            end
            acc_q <= '0;
            ovf_q <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc_q[c] <= 1'b0;
                if (clr[c]) begin
                    cnt[c]   <= '0;
                    ovf_q[c] <= 1'b0;
                    for (int i = 0; i < DEPTH; i++) begin
                        mem[c][i] <= '0;
                    end
                end else if (!lock && rise[c]) begin
                    if (cnt[c] < CW'(DEPTH)) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            if (CW'(i) == cnt[c]) begin
                                mem[c][i] <= d_in[c*WIDTH +: WIDTH];
                            end
                        end
                        cnt[c]   <= cnt[c] + CW'(1);
                        acc_q[c] <= 1'b1;
                    end else begin
                        ovf_q[c] <= 1'b1;
                    end
                end
            end
        end
    end

    // Read mux: only slots below the channel's current count are visible,
    // so a slot being written this cycle still reads as 0.
    // NOTE: rd_sel gets a default before the loop, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        rd_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CHW'(c) == rd_ch && IW'(i) == rd_idx && CW'(i) < cnt[c]) begin
                    rd_sel = mem[c][i];
                end
            end
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_sel;
        end
    end

    // Flatten per-channel state onto the packed output buses.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign count[g*CW +: CW] = cnt[g];
        assign full[g]           = (cnt[g] == CW'(DEPTH));
    end

    assign accepted = acc_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_morse_symbol_buffer.sv
// Scoreboard bench for morse_symbol_buffer (WIDTH=2, DEPTH=8, NUM_CH=2).
// Stimulus pushes expected accept events and read/status probes into queues;
// a monitor on the falling edge pops and compares them as the DUT responds.
module tb_morse_symbol_buffer;

    localparam int WIDTH  = 2;
    localparam int DEPTH  = 8;
    localparam int NUM_CH = 2;
    localparam int CW     = 4;
    localparam int IW     = 3;
    localparam int CHW    = 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       load;
    logic [NUM_CH*WIDTH-1:0] d_in;
    logic [NUM_CH-1:0]       clr;
    logic                    lock;
    logic [CHW-1:0]          rd_ch;
    logic [IW-1:0]           rd_idx;
    logic [WIDTH-1:0]        rd_data;
    logic [NUM_CH*CW-1:0]    count;
    logic [NUM_CH-1:0]       full;
    logic [NUM_CH-1:0]       accepted;
    logic [NUM_CH-1:0]       overflow;

    morse_symbol_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .d_in     (d_in),
        .clr      (clr),
        .lock     (lock),
        .rd_ch    (rd_ch),
        .rd_idx   (rd_idx),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .accepted (accepted),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_CH-1:0]    mask;
        logic [NUM_CH*CW-1:0] cnt;
    } acc_t;

    typedef struct {
        string                tag;
        logic [WIDTH-1:0]     rd;
        logic [NUM_CH*CW-1:0] cnt;
        logic [NUM_CH-1:0]    ovf;
    } probe_t;

    acc_t   acc_q[$];
    probe_t probe_q[$];

    int   n_vec = 0;
    int   n_bad = 0;
    logic probe_req = 1'b0;
    logic probe_vld = 1'b0;

    // Probe results appear on rd_data one edge after the request.
    always @(posedge clk) probe_vld <= probe_req;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Monitor: pops an expected accept on every accept pulse and an
    // expected probe on every probe response.
    always @(negedge clk) begin
        if (accepted !== '0) begin
            if (acc_q.size() == 0) begin
                check("unexpected_accept", 32'(accepted), 32'h0);
            end else begin
                acc_t a;
                a = acc_q.pop_front();
                check("accept_mask", 32'(accepted), 32'(a.mask));
                check("accept_count", 32'(count), 32'(a.cnt));
            end
        end
        if (probe_vld) begin
            if (probe_q.size() == 0) begin
                check("unexpected_probe", 32'h1, 32'h0);
            end else begin
                probe_t p;
                logic [NUM_CH-1:0] exp_full;
                p = probe_q.pop_front();
                exp_full = {p.cnt[CW +: CW] == CW'(DEPTH), p.cnt[0 +: CW] == CW'(DEPTH)};
                check({p.tag, "_rd"}, 32'(rd_data), 32'(p.rd));
                check({p.tag, "_status"}, {20'h0, overflow, full, count},
                      {20'h0, p.ovf, exp_full, p.cnt});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        probe_req = 1'b0;
    endtask

    task automatic arm_probe(input string tag, input logic ch, input logic [IW-1:0] idx,
                             input logic [WIDTH-1:0] rd, input int c0, input int c1,
                             input logic [NUM_CH-1:0] ovf);
        probe_t p;
        p.tag = tag;
        p.rd  = rd;
        p.cnt = {CW'(c1), CW'(c0)};
        p.ovf = ovf;
        probe_q.push_back(p);
        rd_ch     = ch;
        rd_idx    = idx;
        probe_req = 1'b1;
    endtask

    task automatic probe(input string tag, input logic ch, input logic [IW-1:0] idx,
                         input logic [WIDTH-1:0] rd, input int c0, input int c1,
                         input logic [NUM_CH-1:0] ovf);
        arm_probe(tag, ch, idx, rd, c0, c1, ovf);
        tick();
    endtask

    task automatic expect_accept(input logic [NUM_CH-1:0] m, input int c0, input int c1);
        acc_t a;
        a.mask = m;
        a.cnt  = {CW'(c1), CW'(c0)};
        acc_q.push_back(a);
    endtask

    // One press: button high for one cycle, then released for one cycle.
    task automatic press(input logic [NUM_CH-1:0] m, input logic [WIDTH-1:0] d0,
                         input logic [WIDTH-1:0] d1, input logic [NUM_CH-1:0] exp_m,
                         input int c0, input int c1);
        if (exp_m != '0) expect_accept(exp_m, c0, c1);
        load = m;
        d_in = {d1, d0};
        tick();
        load = '0;
        tick();
    endtask

    logic [WIDTH-1:0] seq [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};

    initial begin
        rst = 1'b0; load = 2'b11; d_in = '0; clr = '0; lock = 1'b0;
        rd_ch = '0; rd_idx = '0;
        tick(); tick();
        probe("in_reset", 1'b0, 3'd0, 2'd0, 0, 0, 2'b00);
        rst = 1'b1;
        repeat (5) tick();
        probe("held_thru_rst", 1'b0, 3'd0, 2'd0, 0, 0, 2'b00);
        load = 2'b00;
        tick();
        press(2'b01, 2'b01, 2'b00, 2'b01, 1, 0);
        probe("first_sym", 1'b0, 3'd0, 2'b01, 1, 0, 2'b00);

        clr = 2'b01; tick(); clr = 2'b00;
        probe("clr0", 1'b0, 3'd0, 2'd0, 0, 0, 2'b00);

        for (int i = 0; i < 8; i++) press(2'b01, seq[i], 2'b00, 2'b01, i + 1, 0);
        for (int i = 0; i < 8; i++) probe("fill_rd", 1'b0, 3'(i), seq[i], 8, 0, 2'b00);
        press(2'b01, 2'b10, 2'b00, 2'b00, 8, 0);
        probe("overflow", 1'b0, 3'd7, 2'b01, 8, 0, 2'b01);

        clr = 2'b01; load = 2'b01; d_in = 4'b0011;
        tick();
        clr = 2'b00; load = 2'b00;
        tick();
        probe("clr_vs_rise", 1'b0, 3'd0, 2'd0, 0, 0, 2'b00);

        expect_accept(2'b01, 1, 0);
        load = 2'b01; d_in = 4'b0010;
        repeat (20) tick();
        load = 2'b00;
        tick();
        probe("held_press", 1'b0, 3'd0, 2'b10, 1, 0, 2'b00);
        probe("held_idx1", 1'b0, 3'd1, 2'b00, 1, 0, 2'b00);

        clr = 2'b01; tick(); clr = 2'b00;
        press(2'b11, 2'b10, 2'b01, 2'b11, 1, 1);
        probe("dual_ch1_0", 1'b1, 3'd0, 2'b01, 1, 1, 2'b00);
        probe("dual_ch1_1", 1'b1, 3'd1, 2'b00, 1, 1, 2'b00);
        probe("dual_ch0_0", 1'b0, 3'd0, 2'b10, 1, 1, 2'b00);

        lock = 1'b1;
        repeat (3) press(2'b10, 2'b00, 2'b11, 2'b00, 1, 1);
        lock = 1'b0;
        probe("locked", 1'b1, 3'd0, 2'b01, 1, 1, 2'b00);

        press(2'b10, 2'b00, 2'b10, 2'b10, 1, 2);
        press(2'b10, 2'b00, 2'b00, 2'b10, 1, 3);
        arm_probe("rw_same", 1'b1, 3'd3, 2'b00, 1, 4, 2'b00);
        press(2'b10, 2'b00, 2'b11, 2'b10, 1, 4);
        probe("rw_next", 1'b1, 3'd3, 2'b11, 1, 4, 2'b00);

        rst = 1'b0; tick(); rst = 1'b1;
        probe("mid_reset", 1'b1, 3'd0, 2'b00, 0, 0, 2'b00);
        press(2'b01, 2'b01, 2'b00, 2'b01, 1, 0);
        probe("after_reset", 1'b0, 3'd0, 2'b01, 1, 0, 2'b00);

        tick(); tick();
        check("accepts_pending", 32'(acc_q.size()), 32'h0);
        check("probes_pending", 32'(probe_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
